// File: rtl/sync_cell_pkg.sv
// Shared constants and helpers for the sync_cell level synchronizer.
// Stage-count limits bound the flop chain depth accepted at elaboration.
package sync_cell_pkg;

  localparam int unsigned SYNC_CELL_MIN_STAGES = 2;
  localparam int unsigned SYNC_CELL_MAX_STAGES = 8;
  localparam int unsigned SYNC_CELL_DEF_STAGES = 2;

  // True when a requested chain depth is inside the supported range.
  function automatic bit sync_cell_stages_ok(int unsigned stages);
    return (stages >= SYNC_CELL_MIN_STAGES) && (stages <= SYNC_CELL_MAX_STAGES);
  endfunction

endpackage

// File: rtl/sync_cell_bit_if.sv
// Bundle of the data-path signals of sync_cell_bit.
//   async_in   : asynchronous level from another domain (driven by master)
//   sync_out   : synchronized level (driven by slave)
//   rise_pulse : one-cycle pulse on 0->1 of sync_out (driven by slave)
//   fall_pulse : one-cycle pulse on 1->0 of sync_out (driven by slave)
// The slave modport is the synchronizer; the master modport is its user.
interface sync_cell_bit_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_pulse,
    output fall_pulse
  );

endinterface

// File: rtl/sync_cell_chain.sv
// Single-bit flop chain used as a metastability synchronizer.
//   clk : destination clock, rising edge
//   rst : asynchronous reset, active-high; every stage loads RESET_VAL
//   d   : asynchronous input bit
//   q   : last stage of the chain
// Stages are plain back-to-back flops with no logic between them.
module sync_cell_chain
  import sync_cell_pkg::*;
#(
  parameter int unsigned STAGES    = SYNC_CELL_DEF_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Kept adjacent by placement so the resolution window is maximised.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {STAGES{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_cell_bit.sv
// Multi-flop synchronizer: brings an asynchronous level bus into the clk domain,
// each bit independently (no bus coherency).
//   clk : destination clock, rising edge
//   rst : asynchronous reset, active-high (not synchronized here)
//   bus : sync_cell_bit_if slave modport (async_in, sync_out, rise_pulse, fall_pulse)
// Optional feature macro: SYNC_CELL_EDGE_DET_EN builds a history flop and drives
// single-cycle rise/fall pulses aligned with sync_out changes; otherwise the pulse
// outputs are tied low and no history flop exists.
module sync_cell_bit
  import sync_cell_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = SYNC_CELL_DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  sync_cell_bit_if.slave bus
);

  if (!sync_cell_stages_ok(STAGES)) begin : g_stages_err
    $error("sync_cell_bit: STAGES must be within 2..8");
  end

  logic [WIDTH-1:0] sync_val;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_cell_chain #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[i])
    ) u_chain (
      .clk (clk),
      .rst (rst),
      .d   (bus.async_in[i]),
      .q   (sync_val[i])
    );
  end

  assign bus.sync_out = sync_val;

`ifdef SYNC_CELL_EDGE_DET_EN
  // Reset to RESET_VAL so sync_val == prev_q out of reset and no pulse fires.
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sync_val;
    end
  end

  assign bus.rise_pulse = sync_val & ~prev_q;
  assign bus.fall_pulse = ~sync_val & prev_q;
`else
  assign bus.rise_pulse = '0;
  assign bus.fall_pulse = '0;
`endif

endmodule

// File: tb/tb_sync_cell_bit.sv
// Bench for sync_cell_bit: two instances (1-bit/2-stage/reset 0 and
// 4-bit/3-stage/reset 4'hA) checked against a sample-history model.
module tb_sync_cell_bit;

  localparam int unsigned       STAGES_A = 2;
  localparam int unsigned       STAGES_B = 3;
  localparam logic              RST_A    = 1'b0;
  localparam logic [3:0]        RST_B    = 4'hA;

  logic clk;
  logic rst;

  sync_cell_bit_if #(.WIDTH(1)) bus_a ();
  sync_cell_bit_if #(.WIDTH(4)) bus_b ();

  sync_cell_bit #(
    .WIDTH     (1),
    .STAGES    (STAGES_A),
    .RESET_VAL (RST_A)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_cell_bit #(
    .WIDTH     (4),
    .STAGES    (STAGES_B),
    .RESET_VAL (RST_B)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the last STAGES values sampled at rising edges; the oldest is what
  // sync_out must show. prev_* is the level shown one cycle earlier.
  logic       hist_a[$];
  logic [3:0] hist_b[$];
  logic       prev_a;
  logic [3:0] prev_b;

  task automatic model_reset();
    hist_a = {};
    hist_b = {};
    for (int i = 0; i < STAGES_A; i++) hist_a.push_back(RST_A);
    for (int i = 0; i < STAGES_B; i++) hist_b.push_back(RST_B);
    prev_a = RST_A;
    prev_b = RST_B;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      prev_a = hist_a[0];
      prev_b = hist_b[0];
      hist_a.push_back(bus_a.async_in[0]);
      hist_b.push_back(bus_b.async_in);
      void'(hist_a.pop_front());
      void'(hist_b.pop_front());
    end
  endtask

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic       ea;
    logic [3:0] eb;
    logic       ra, fa;
    logic [3:0] rb, fb;
    ea = hist_a[0];
    eb = hist_b[0];
`ifdef SYNC_CELL_EDGE_DET_EN
    ra = ea & ~prev_a;
    fa = ~ea & prev_a;
    rb = eb & ~prev_b;
    fb = ~eb & prev_b;
`else
    ra = 1'b0;
    fa = 1'b0;
    rb = 4'h0;
    fb = 4'h0;
`endif
    check({tag, ".a.sync"}, {3'b0, bus_a.sync_out[0]}, {3'b0, ea});
    check({tag, ".a.rise"}, {3'b0, bus_a.rise_pulse[0]}, {3'b0, ra});
    check({tag, ".a.fall"}, {3'b0, bus_a.fall_pulse[0]}, {3'b0, fa});
    check({tag, ".b.sync"}, bus_b.sync_out, eb);
    check({tag, ".b.rise"}, bus_b.rise_pulse, rb);
    check({tag, ".b.fall"}, bus_b.fall_pulse, fb);
  endtask

  // Advance one edge; inputs only change away from edges, so sampling is exact.
  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int hi_cnt;

    // 1: reset 0..20 ns
    rst = 1'b1;
    bus_a.async_in = 1'b0;
    bus_b.async_in = 4'h0;
    model_reset();
    #1;
    check_all("reset");
    check("reset.b.lit", bus_b.sync_out, 4'hA);
    #19 rst = 1'b0;
    tick("post_rst");                                  // edge 25, now 26
    check("post_rst.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h0);

    // 2: rise at 30 -> sync_out 1 at 45
    #4 bus_a.async_in = 1'b1;                          // 30
    tick("rise1");                                     // 35
    check("rise1.a.still0", {3'b0, bus_a.sync_out[0]}, 4'h0);
    tick("rise2");                                     // 45
    check("rise2.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h1);
    tick("rise3");                                     // 55

    // 3: alternating levels
    #4 bus_a.async_in = 1'b0;                          // 60
    tick("fall1");
    tick("fall2");                                     // 75
    check("fall2.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h0);
    tick("fall3");
    #4 bus_a.async_in = 1'b1;                          // 90
    tick("alt1");
    tick("alt2");                                      // 105
    check("alt2.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h1);
    tick("alt3");
    #4 bus_a.async_in = 1'b0;                          // 120
    tick("alt4");
    tick("alt5");                                      // 135
    check("alt5.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h0);

    // 4a: 3 ns glitch between edges is never sampled
    #2 bus_a.async_in = 1'b1;
    #3 bus_a.async_in = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick("glitch");
      if (bus_a.sync_out[0] === 1'b1) hi_cnt++;
    end
    check("glitch.count", hi_cnt[3:0], 4'h0);

    // 4b: 12 ns pulse spanning one edge -> exactly one high cycle
    #3 bus_a.async_in = 1'b1;
    tick("p12.a");
    #5 bus_a.async_in = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick("p12.b");
      if (bus_a.sync_out[0] === 1'b1) hi_cnt++;
    end
    check("p12.count", hi_cnt[3:0], 4'h1);

    // 5: mid-operation reset with a 1 in stage0, no clock edge involved
    #1 begin
      bus_a.async_in = 1'b1;
      bus_b.async_in = 4'h5;
    end
    tick("pre_mrst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    check("mid_rst.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h0);
    check("mid_rst.b.lit", bus_b.sync_out, 4'hA);
    #2 rst = 1'b0;
    tick("rel1");
    check("rel1.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h0);
    tick("rel2");
    check("rel2.a.lit", {3'b0, bus_a.sync_out[0]}, 4'h1);

    // 6: 4-bit, 3-stage instance reaches 4'h5 on the third edge
    check("rel2.b.notyet", bus_b.sync_out, 4'hA);
    tick("rel3");
    check("rel3.b.lit", bus_b.sync_out, 4'h5);

    // Random levels, occasionally changed at random points between edges
    for (int i = 0; i < 300; i++) begin
      #($urandom_range(1, 7));
      if ($urandom_range(0, 2) == 0) bus_a.async_in = 1'($urandom);
      if ($urandom_range(0, 2) == 0) bus_b.async_in = 4'($urandom);
      if (i == 150) begin
        rst = 1'b1;
        #1 model_reset();
        check_all("rnd_rst");
        rst = 1'b0;
      end
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
